// File: rtl/iter_shifter.sv
// Multi-cycle shift unit (SLL/SRL/SRA/ROTR) that shifts up to STEP bits per
// cycle. A start/busy/done handshake is used so it can hang off a multi-cycle ALU.
module iter_shifter #(
    parameter int WIDTH = 32,
    parameter int SA_W  = $clog2(WIDTH),
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SA_W-1:0]  sa,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b11;
    localparam logic [1:0] OP_ROTR = 2'b10;

    // One extra bit so that STEP == WIDTH is representable.
    localparam logic [SA_W:0] STEP_X = (SA_W+1)'(STEP);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [1:0]         op_q, op_d;
    logic               sign_q, sign_d;
    logic [SA_W-1:0]    rem_q, rem_d;
    logic               done_q, done_d;

    logic [SA_W-1:0]    amt;
    logic [SA_W-1:0]    rem_after;
    logic [WIDTH-1:0]   shifted;

    // Per-cycle step; amt never exceeds rem, so rem_after cannot underflow.
    always_comb begin
        amt       = ({1'b0, rem_q} >= STEP_X) ? STEP_X[SA_W-1:0] : rem_q;
        rem_after = rem_q - amt;
        case (op_q)
            OP_SLL:  shifted = work_q << amt;
            OP_SRL:  shifted = work_q >> amt;
            OP_SRA:  shifted = WIDTH'({{WIDTH{sign_q}}, work_q} >> amt);
            OP_ROTR: shifted = WIDTH'({work_q, work_q} >> amt);
            default: shifted = work_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        result_d = result_q;
        op_d     = op_q;
        sign_d   = sign_q;
        rem_d    = rem_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    work_d  = data_in;
                    op_d    = op;
                    sign_d  = data_in[WIDTH-1];
                    rem_d   = sa;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                work_d = shifted;
                rem_d  = rem_after;
                if (rem_after == '0) begin
                    result_d = shifted;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            work_q   <= '0;
            result_q <= '0;
            op_q     <= OP_SLL;
            sign_q   <= 1'b0;
            rem_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            result_q <= result_d;
            op_q     <= op_d;
            sign_q   <= sign_d;
            rem_q    <= rem_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q == SHIFT);
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Bench for iter_shifter (WIDTH=32, STEP=4): a vector table plus hand-written
// sequences for busy-time starts, back-to-back operation and mid-op reset.
module tb_iter_shifter;

    localparam int WIDTH = 32;
    localparam int SA_W  = 5;
    localparam int STEP  = 4;

    localparam logic [1:0] SLL  = 2'b00;
    localparam logic [1:0] SRL  = 2'b01;
    localparam logic [1:0] SRA  = 2'b11;
    localparam logic [1:0] ROTR = 2'b10;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        logic [4:0]  sa;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [1:0]        op = 2'b00;
    logic [WIDTH-1:0]  data_in = '0;
    logic [SA_W-1:0]   sa = '0;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  result;

    int                checks = 0;
    int                errors = 0;
    logic [31:0]       exp_q[$];
    logic [31:0]       prev_result = '0;
    vec_t              vecs[12];

    iter_shifter #(.WIDTH(WIDTH), .SA_W(SA_W), .STEP(STEP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .data_in(data_in),
        .sa(sa), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge; drives the request for one cycle and waits for done.
    task automatic run_op(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s,
                          input logic [31:0] e, input int lat, input string name);
        int cyc;
        logic [31:0] want;
        start = 1'b1; op = o; data_in = d; sa = s;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0; op = 2'($urandom); data_in = $urandom; sa = 5'($urandom);
        check({name, " busy"}, 32'(busy), 32'd1);
        cyc = 0;
        while (!done && cyc < 64) begin
            check({name, " hold"}, result, prev_result);
            @(negedge clk);
            cyc++;
        end
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check({name, " latency"}, 32'(cyc), 32'(lat));
        check({name, " done_busy"}, 32'(busy), 32'd0);
        check({name, " result"}, result, want);
        prev_result = want;
        $display("op=%0d data=0x%08h sa=%0d result=0x%08h latency=%0d", o, d, s, result, cyc);
    endtask

    task automatic end_pulse(input string name);
        @(negedge clk);
        check({name, " done_fall"}, 32'(done), 32'd0);
        check({name, " idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int pulses;
        vecs[0]  = '{SLL,  32'h0000_0001, 5'd4,  32'h0000_0010, 1};
        vecs[1]  = '{SRA,  32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 8};
        vecs[2]  = '{SRL,  32'h8000_0000, 5'd31, 32'h0000_0001, 8};
        vecs[3]  = '{ROTR, 32'h0000_0001, 5'd1,  32'h8000_0000, 1};
        vecs[4]  = '{SLL,  32'h1234_5678, 5'd0,  32'h1234_5678, 1};
        vecs[5]  = '{SRL,  32'hF000_0000, 5'd12, 32'h000F_0000, 3};
        vecs[6]  = '{ROTR, 32'h1234_5678, 5'd8,  32'h7812_3456, 2};
        vecs[7]  = '{SRA,  32'h7FFF_FFFF, 5'd5,  32'h03FF_FFFF, 2};
        vecs[8]  = '{SRA,  32'hF000_0000, 5'd0,  32'hF000_0000, 1};
        vecs[9]  = '{ROTR, 32'h8000_0001, 5'd31, 32'h0000_0003, 8};
        vecs[10] = '{SLL,  32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 8};
        vecs[11] = '{SRA,  32'h8000_0000, 5'd4,  32'hF800_0000, 1};

        #12;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].data, vecs[i].sa, vecs[i].exp, vecs[i].lat,
                   $sformatf("vec%0d", i));
            end_pulse($sformatf("vec%0d", i));
        end

        // A start pulsed while busy must be ignored.
        start = 1'b1; op = SLL; data_in = 32'h0000_00FF; sa = 5'd8;
        exp_q.push_back(32'h0000_FF00);
        @(negedge clk);
        check("ign busy", 32'(busy), 32'd1);
        start = 1'b1; op = SRL; data_in = 32'hFFFF_FFFF; sa = 5'd1;
        @(negedge clk);
        start = 1'b0;
        check("ign early_done", 32'(done), 32'd0);
        check("ign hold", result, prev_result);
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                check("ign result", result, (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF);
            end
        end
        check("ign pulses", 32'(pulses), 32'd1);
        check("ign idle", 32'(busy), 32'd0);
        prev_result = 32'h0000_FF00;
        $display("op=%0d data=0x%08h sa=%0d result=0x%08h pulses=%0d", SLL, 32'h0000_00FF, 8, result, pulses);

        // Back-to-back: second request driven in the done cycle of the first.
        run_op(SLL, 32'h0000_00FF, 5'd8, 32'h0000_FF00, 2, "b2b_a");
        run_op(SRL, 32'hF000_0000, 5'd12, 32'h000F_0000, 3, "b2b_b");
        end_pulse("b2b_b");

        // Reset mid-operation discards the op and clears outputs at once.
        start = 1'b1; op = SRA; data_in = 32'h8000_0000; sa = 5'd20;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_result = '0;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("rst no_done", 32'(pulses), 32'd0);
        $display("reset mid-op: result=0x%08h spurious_done=%0d", result, pulses);
        run_op(SRA, 32'h8000_0000, 5'd20, 32'hFFFF_F800, 5, "post_rst");
        end_pulse("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
